clk_div_ctrl: RTL and testbench

- Programmable integer clock divider controller; generalises the fixed divide-by-3 50%-duty divider into a runtime-configurable one.
- Sequences start/stop and applies divide-ratio changes glitch-free, only at output period boundaries, with 50% duty cycle for both odd and even ratios.
- Sits between the clock-configuration register interface and downstream logic that consumes the divided clock.

---
 rtl/clk_div_ctrl.sv | 83 ++++++++
 tb/tb_clk_div_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable 50%-duty integer clock divider with glitch-free
// start/stop and ratio changes applied only at output period boundaries.
module clk_div_ctrl #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             y,
    output logic [WIDTH-1:0] cur_div,
    output logic             running,
    output logic             period_tick
);
    typedef enum logic [1:0] {IDLE, RUN, PEND, STOPPING} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] cnt, pend, half;
    logic pend_v, act, pos_q, neg_q, accept, ok, wrap, start, stop_done;

    assign accept    = cfg_valid & cfg_ready;
    assign ok        = cfg_div >= WIDTH'(2);
    assign half      = (cur_div >> 1) + WIDTH'(cur_div[0]);
    // act marks a period in progress; the first RUN cycle after IDLE has none yet
    assign wrap      = act && (cnt == cur_div - WIDTH'(1));
    assign start     = (state == RUN || state == PEND) && (!act || wrap);
    assign stop_done = (state == STOPPING) && wrap;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state == IDLE     ? (en ? RUN : IDLE) :
                   state == STOPPING ? (wrap ? IDLE : STOPPING) :
                   !en               ? STOPPING :
                   state == RUN      ? ((accept && ok) ? PEND : RUN) :
                                       (wrap ? RUN : PEND);
    end

    always_comb begin
        running   = state != IDLE;
        cfg_ready = state == IDLE || state == RUN;
        // odd ratios trim half a cycle off the front of the high phase via neg_q
        y         = running & pos_q & (cur_div[0] ? neg_q : 1'b1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            act         <= 1'b0;
            pos_q       <= 1'b0;
            pend        <= '0;
            pend_v      <= 1'b0;
            cur_div     <= WIDTH'(RESET_DIV);
            cfg_err     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            cfg_err     <= accept & ~ok;
            period_tick <= start;
            act         <= start | (act & ~stop_done);
            cnt         <= (start || stop_done) ? '0 : act ? cnt + WIDTH'(1) : cnt;
            pos_q       <= start ? 1'b1 : (act && !stop_done) ? ((cnt + WIDTH'(1)) < half) : 1'b0;
            if (accept && ok && state == IDLE)
                cur_div <= cfg_div;
            else if (pend_v && wrap)
                cur_div <= pend;
            if (accept && ok && state == RUN) begin
                pend   <= cfg_div;
                pend_v <= 1'b1;
            end else if (pend_v && wrap) begin
                pend_v <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk or posedge rst)
        if (rst) neg_q <= 1'b0;
        else     neg_q <= pos_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed vector table, hand-written corner sequences and random
// traffic, all checked per half clock cycle against a period-level reference model.
module tb_clk_div_ctrl;
    localparam int W = 8;
    logic clk = 1'b0, rst, en, cfg_valid;
    logic [W-1:0] cfg_div, cur_div;
    logic cfg_ready, cfg_err, y, running, period_tick;
    int checks = 0, errors = 0;
    int hi = 0;
    logic last_y;

    clk_div_ctrl #(.WIDTH(W), .RESET_DIV(3)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .y(y), .cur_div(cur_div),
        .running(running), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // model: whether output is active, position p within the current period of length n
    bit m_run, m_started, m_stop, m_err, m_tick;
    int m_p, m_n, m_pend;

    function automatic bit m_ready();
        return !m_run || (m_pend < 0 && !m_stop);
    endfunction

    // half-slot s counts half cycles from period start; the high phase covers n of them
    function automatic bit m_y(int h);
        int s;
        s = 2 * m_p + h;
        if (!(m_run && m_started)) return 1'b0;
        return (m_n % 2 == 0) ? (s < m_n) : (s >= 1 && s <= m_n);
    endfunction

    task automatic m_reset();
        m_run = 0; m_started = 0; m_stop = 0; m_err = 0; m_tick = 0;
        m_p = 0; m_n = 3; m_pend = -1;
    endtask

    task automatic m_step();
        bit acc, ok, wrap, old_stop;
        int old_pend;
        acc = cfg_valid && m_ready();
        ok = cfg_div >= 2;
        m_err = acc && !ok;
        m_tick = 0;
        wrap = m_run && m_started && (m_p == m_n - 1);
        old_stop = m_stop;
        old_pend = m_pend;
        if (!m_run) begin
            if (acc && ok) m_n = cfg_div;
            if (en) begin m_run = 1; m_started = 0; end
        end else begin
            if (acc && ok) m_pend = cfg_div;
            if (wrap && old_stop) begin
                m_run = 0; m_started = 0; m_stop = 0; m_p = 0;
                if (m_pend >= 0) begin m_n = m_pend; m_pend = -1; end
            end else begin
                if (!en) m_stop = 1;
                if (!m_started || wrap) begin
                    m_p = 0; m_started = 1; m_tick = 1;
                    if (wrap && old_pend >= 0) begin m_n = old_pend; m_pend = -1; end
                end else m_p++;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pulse_track();
        if (y === 1'b1) hi++;
        else if (hi > 0) begin
            chk("min_pulse_ok", hi >= 2, 1);
            hi = 0;
        end
    endtask

    task automatic cyc(bit e, bit v, int d);
        en = e; cfg_valid = v; cfg_div = W'(d);
        @(posedge clk);
        m_step();
        #1;
        chk("y_first_half", y, m_y(0));
        chk("running", running, m_run);
        chk("cfg_ready", cfg_ready, m_ready());
        chk("cfg_err", cfg_err, m_err);
        chk("period_tick", period_tick, m_tick);
        chk("cur_div", cur_div, m_n);
        pulse_track();
        @(negedge clk);
        #1;
        chk("y_second_half", y, m_y(1));
        pulse_track();
        last_y = y;
    endtask

    typedef struct {
        bit en, v;
        int d;
        bit run, rdy, err, tick;
        int cur;
    } vec_t;
    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 0, 0, 1, 1, 0, 0, 3};
        tbl[1] = '{1, 0, 0, 1, 1, 0, 1, 3};
        tbl[2] = '{1, 1, 4, 1, 0, 0, 0, 3};
        tbl[3] = '{1, 0, 0, 1, 0, 0, 0, 3};
        tbl[4] = '{1, 0, 0, 1, 1, 0, 1, 4};
        tbl[5] = '{1, 1, 1, 1, 1, 1, 0, 4};
        tbl[6] = '{1, 1, 0, 1, 1, 1, 0, 4};
        tbl[7] = '{1, 0, 0, 1, 1, 0, 0, 4};
        tbl[8] = '{1, 0, 0, 1, 1, 0, 1, 4};

        rst = 1; en = 0; cfg_valid = 0; cfg_div = '0; last_y = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y", y, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_cur_div", cur_div, 3);
        chk("rst_err", cfg_err, 0);
        chk("rst_tick", period_tick, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].en, tbl[i].v, tbl[i].d);
            chk("tbl_running", running, tbl[i].run);
            chk("tbl_ready", cfg_ready, tbl[i].rdy);
            chk("tbl_err", cfg_err, tbl[i].err);
            chk("tbl_tick", period_tick, tbl[i].tick);
            chk("tbl_cur_div", cur_div, tbl[i].cur);
        end

        // ratio 5 then 2 across boundaries
        cyc(1, 1, 5);
        repeat (12) cyc(1, 0, 0);
        cyc(1, 1, 2);
        repeat (10) cyc(1, 0, 0);
        chk("ratio_2_applied", cur_div, 2);

        // stop mid-period with N=5, then restart
        for (int i = 0; i < 10 && !cfg_ready; i++) cyc(1, 0, 0);
        cyc(1, 1, 5);
        repeat (8) cyc(1, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < 12 && running; i++) cyc(0, 0, 0);
        chk("stop_reached_idle", running, 0);
        repeat (14) cyc(1, 0, 0);

        // async reset while y is high and a ratio is pending
        for (int i = 0; i < 12 && !period_tick; i++) cyc(1, 0, 0);
        chk("tick_before_rst", period_tick, 1);
        cyc(1, 1, 7);
        chk("y_high_before_rst", last_y, 1);
        chk("pending_before_rst", cfg_ready, 0);
        rst = 1;
        #1;
        chk("async_rst_y", y, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_cur_div", cur_div, 3);
        chk("async_rst_ready", cfg_ready, 1);
        m_reset();
        hi = 0;
        @(negedge clk);
        rst = 0;
        repeat (12) cyc(1, 0, 0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(15) != 0, $urandom_range(7) == 0,
                ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(6)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
